// File: rtl/galaga_pkg.sv
// Shared Galaga definitions: enemy fire states, row ship x table,
// laser geometry/colour and a box overlap helper.
package galaga_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COOLDOWN,
      FLYING,
      HIT
   } fire_state_t;

   localparam int          NUM_SHIPS    = 6;
   localparam int          LASER_W      = 2;
   localparam int          LASER_H      = 8;
   localparam logic [9:0]  LASER_EXIT_Y = 10'd472;
   localparam logic [23:0] LASER_COLOR  = 24'hFF0000;

   // Row ship i sits at x = 50*(i+1).
   function automatic logic [9:0] ship_x(input logic [2:0] idx);
      case (idx)
         3'd0:    return 10'd50;
         3'd1:    return 10'd100;
         3'd2:    return 10'd150;
         3'd3:    return 10'd200;
         3'd4:    return 10'd250;
         3'd5:    return 10'd300;
         default: return 10'd0;
      endcase
   endfunction

   // Half-open boxes [x, x+w) x [y, y+h); widened to 11 bits so edges never wrap.
   function automatic logic boxes_overlap(
      input logic [10:0] ax, input logic [10:0] ay,
      input logic [10:0] aw, input logic [10:0] ah,
      input logic [10:0] bx, input logic [10:0] by,
      input logic [10:0] bw, input logic [10:0] bh
   );
      return (ax < bx + bw) && (bx < ax + aw) &&
             (ay < by + bh) && (by < ay + ah);
   endfunction

endpackage

// File: rtl/rr_shooter_sel.sv
// Round-robin shooter picker: first alive row ship strictly after last_idx,
// wrapping 5 -> 0.
module rr_shooter_sel
   import galaga_pkg::*;
(
   input  logic [5:0] alive_mask,
   input  logic [2:0] last_idx,
   output logic [2:0] next_idx,
   output logic       valid
);

   logic [3:0] cand;

   // Scan from the farthest candidate to the nearest so the nearest alive one wins.
   always_comb begin
      next_idx = last_idx;
      valid    = 1'b0;
      cand     = 4'd0;
      for (int k = NUM_SHIPS; k >= 1; k--) begin
         cand = {1'b0, last_idx} + 4'(k);
         if (cand >= 4'(NUM_SHIPS)) begin
            cand = cand - 4'(NUM_SHIPS);
         end
         if (alive_mask[cand[2:0]]) begin
            next_idx = cand[2:0];
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/enemy_fire_ctrl.sv
// Enemy fire controller: paces shots from the enemy row, flies a laser down
// the screen one step per frame and reports hits on the user ship.
module enemy_fire_ctrl
   import galaga_pkg::*;
#(
   parameter int FIRE_PERIOD = 90,
   parameter int LASER_STEP  = 4,
   parameter int ESHIP_W     = 32
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic        play,
   input  logic        done,
   input  logic [5:0]  alive_mask,
   input  logic [9:0]  y_offset,
   input  logic [9:0]  user_ship_x_pos,
   input  logic [9:0]  user_ship_y_pos,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic        is_enemy_laser,
   output logic [23:0] enemy_laser_data,
   output logic        user_hit,
   output logic        laser_active
);

   localparam int                CNT_W       = (FIRE_PERIOD > 1) ? $clog2(FIRE_PERIOD) : 1;
   localparam logic [CNT_W-1:0]  CNT_RELOAD  = CNT_W'(FIRE_PERIOD - 1);
   localparam logic [9:0]        LASER_X_OFS = 10'(ESHIP_W / 2 - 1);
   localparam logic [9:0]        SHIP_SIZE10 = 10'(ESHIP_W);
   localparam logic [10:0]       SHIP_SIZE   = 11'(ESHIP_W);
   localparam logic [10:0]       STEP        = 11'(LASER_STEP);

   fire_state_t      state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, cnt_dec;
   logic [2:0]       ptr, ptr_n;
   logic [9:0]       laser_x, laser_x_n;
   logic [9:0]       laser_y, laser_y_n;
   logic             frame_d;
   logic             frame_tick;
   logic [2:0]       sel_idx;
   logic             sel_valid;
   logic [10:0]      y_step;
   logic             hit_now;
   logic             hit_at_exit;

   rr_shooter_sel u_sel (
      .alive_mask (alive_mask),
      .last_idx   (ptr),
      .next_idx   (sel_idx),
      .valid      (sel_valid)
   );

   assign frame_tick = frame_clk & ~frame_d;
   assign y_step     = {1'b0, laser_y} + STEP;
   assign cnt_dec    = (cnt == '0) ? '0 : cnt - CNT_W'(1);

   assign hit_now = boxes_overlap({1'b0, laser_x}, {1'b0, laser_y},
                                  11'(LASER_W), 11'(LASER_H),
                                  {1'b0, user_ship_x_pos}, {1'b0, user_ship_y_pos},
                                  SHIP_SIZE, SHIP_SIZE);

   // Position the laser would reach on an exit tick, so a hit there still counts.
   assign hit_at_exit = boxes_overlap({1'b0, laser_x}, y_step,
                                      11'(LASER_W), 11'(LASER_H),
                                      {1'b0, user_ship_x_pos}, {1'b0, user_ship_y_pos},
                                      SHIP_SIZE, SHIP_SIZE);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         ptr     <= 3'd5;
         laser_x <= '0;
         laser_y <= '0;
         frame_d <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         ptr     <= ptr_n;
         laser_x <= laser_x_n;
         laser_y <= laser_y_n;
         frame_d <= frame_clk;
      end
   end

   // done overrides everything; otherwise play low freezes all but the HIT exit.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      ptr_n     = ptr;
      laser_x_n = laser_x;
      laser_y_n = laser_y;
      if (done) begin
         state_n   = IDLE;
         cnt_n     = '0;
         ptr_n     = 3'd5;
         laser_x_n = '0;
         laser_y_n = '0;
      end else begin
         case (state)
            IDLE: begin
               if (play && frame_tick) begin
                  state_n = COOLDOWN;
                  cnt_n   = CNT_RELOAD;
               end
            end
            COOLDOWN: begin
               if (play && frame_tick) begin
                  cnt_n = cnt_dec;
                  if ((cnt_dec == '0) && sel_valid) begin
                     state_n   = FLYING;
                     ptr_n     = sel_idx;
                     laser_x_n = ship_x(sel_idx) + LASER_X_OFS;
                     laser_y_n = y_offset + SHIP_SIZE10;
                  end
               end
            end
            FLYING: begin
               if (play) begin
                  if (hit_now) begin
                     state_n = HIT;
                  end else if (frame_tick) begin
                     if (y_step >= {1'b0, LASER_EXIT_Y}) begin
                        if (hit_at_exit) begin
                           state_n = HIT;
                        end else begin
                           state_n = COOLDOWN;
                           cnt_n   = CNT_RELOAD;
                        end
                     end else begin
                        laser_y_n = y_step[9:0];
                     end
                  end
               end
            end
            HIT: begin
               state_n = COOLDOWN;
               cnt_n   = CNT_RELOAD;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   assign laser_active     = (state == FLYING);
   assign user_hit         = (state == HIT) && !done;
   assign enemy_laser_data = LASER_COLOR;

   assign is_enemy_laser = laser_active &&
                           ({1'b0, DrawX} >= {1'b0, laser_x}) &&
                           ({1'b0, DrawX} <= {1'b0, laser_x} + 11'(LASER_W - 1)) &&
                           ({1'b0, DrawY} >= {1'b0, laser_y}) &&
                           ({1'b0, DrawY} <= {1'b0, laser_y} + 11'(LASER_H - 1));

endmodule

// File: tb/tb_enemy_fire_ctrl.sv
// Self-checking bench for enemy_fire_ctrl: directed shot/hit/freeze/done
// sequences, a pixel table, and random frames against a frame-level model.
module tb_enemy_fire_ctrl;

   localparam int FIRE_PERIOD = 90;
   localparam int LASER_STEP  = 4;
   localparam int ESHIP_W     = 32;
   localparam int EXIT_Y      = 472;

   localparam int PROBE_DX [6] = '{0, 1, -1, 2,  0, 1};
   localparam int PROBE_DY [6] = '{0, 7,  0, 0, -1, 8};
   localparam bit PROBE_EX [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   typedef struct {
      int   dx;
      int   dy;
      logic exp_pix;
   } pix_vec_t;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        frame_clk;
   logic        play;
   logic        done;
   logic [5:0]  alive_mask;
   logic [9:0]  y_offset;
   logic [9:0]  user_ship_x_pos;
   logic [9:0]  user_ship_y_pos;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        is_enemy_laser;
   logic [23:0] enemy_laser_data;
   logic        user_hit;
   logic        laser_active;

   int checks     = 0;
   int errors     = 0;
   int hit_pulses = 0;

   // Frame-level reference model of the fire behaviour.
   bit m_started;
   bit m_fly;
   int m_wait;
   int m_lx;
   int m_ly;
   int m_last;
   int m_hits = 0;

   pix_vec_t pix_tab [10];

   enemy_fire_ctrl dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .frame_clk        (frame_clk),
      .play             (play),
      .done             (done),
      .alive_mask       (alive_mask),
      .y_offset         (y_offset),
      .user_ship_x_pos  (user_ship_x_pos),
      .user_ship_y_pos  (user_ship_y_pos),
      .DrawX            (DrawX),
      .DrawY            (DrawY),
      .is_enemy_laser   (is_enemy_laser),
      .enemy_laser_data (enemy_laser_data),
      .user_hit         (user_hit),
      .laser_active     (laser_active)
   );

   always #10 Clk = ~Clk;

   // Every Clk cycle with user_hit high counts, so a stretched pulse shows up.
   always @(negedge Clk) begin
      if (user_hit === 1'b1) hit_pulses++;
   end

   initial begin
      #4000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   function automatic bit m_overlap(input int lx, input int ly);
      int ux;
      int uy;
      ux = int'(user_ship_x_pos);
      uy = int'(user_ship_y_pos);
      return (lx < ux + ESHIP_W) && (ux < lx + 2) &&
             (ly < uy + ESHIP_W) && (uy < ly + 8);
   endfunction

   task automatic model_reset();
      m_started = 1'b0;
      m_fly     = 1'b0;
      m_wait    = 0;
      m_last    = 5;
   endtask

   task automatic model_tick(input bit p);
      int ny;
      int c;
      if (!p) return;
      if (!m_started) begin
         m_started = 1'b1;
         m_wait    = FIRE_PERIOD - 1;
         return;
      end
      if (m_fly) begin
         ny = m_ly + LASER_STEP;
         if (ny >= EXIT_Y) begin
            if (m_overlap(m_lx, ny)) m_hits++;
            m_fly  = 1'b0;
            m_wait = FIRE_PERIOD - 1;
         end else begin
            m_ly = ny;
            if (m_overlap(m_lx, m_ly)) begin
               m_hits++;
               m_fly  = 1'b0;
               m_wait = FIRE_PERIOD - 1;
            end
         end
      end else begin
         if (m_wait > 0) m_wait--;
         if (m_wait == 0 && alive_mask != 6'd0) begin
            for (int k = 1; k <= 6; k++) begin
               c = (m_last + k) % 6;
               if (alive_mask[c]) begin
                  m_last = c;
                  break;
               end
            end
            m_fly = 1'b1;
            m_lx  = 50 * (m_last + 1) + ESHIP_W / 2 - 1;
            m_ly  = int'(y_offset) + ESHIP_W;
            if (m_overlap(m_lx, m_ly)) begin
               m_hits++;
               m_fly  = 1'b0;
               m_wait = FIRE_PERIOD - 1;
            end
         end
      end
   endtask

   // Drives the 2x8 box edges and their outside neighbours through DrawX/DrawY.
   task automatic probe_laser(input int lx, input int ly, output bit ok);
      ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         DrawX = 10'(lx + PROBE_DX[i]);
         DrawY = 10'(ly + PROBE_DY[i]);
         #1;
         if (is_enemy_laser !== PROBE_EX[i]) ok = 1'b0;
      end
   endtask

   // One frame tick (frame_clk high for one Clk), then compare against the model.
   task automatic applyStimulus(input logic p, input logic [5:0] mask);
      bit ok;
      @(negedge Clk);
      play       = p;
      alive_mask = mask;
      frame_clk  = 1'b1;
      @(negedge Clk);
      frame_clk = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      model_tick(p);
      checkOutput("laser_active", laser_active, m_fly);
      checkOutput("hit_count", hit_pulses, m_hits);
      if (m_fly) begin
         probe_laser(m_lx, m_ly, ok);
         checkOutput("laser_pos", ok, 1'b1);
      end
   endtask

   task automatic wait_laser(input logic want, input logic [5:0] mask,
                             input int max_ticks, input string name);
      int n;
      n = 0;
      while (laser_active !== want && n < max_ticks) begin
         applyStimulus(1'b1, mask);
         n++;
      end
      checkOutput(name, laser_active, want);
   endtask

   task automatic do_done();
      @(negedge Clk);
      done = 1'b1;
      @(posedge Clk);
      #1;
      checkOutput("done_laser_off", laser_active, 1'b0);
      checkOutput("done_no_hit", user_hit, 1'b0);
      @(negedge Clk);
      done = 1'b0;
      model_reset();
   endtask

   initial begin
      bit         ok;
      int         h0;
      int         n;
      logic [5:0] mask;

      pix_tab[0] = '{0, 0, 1'b1};
      pix_tab[1] = '{1, 0, 1'b1};
      pix_tab[2] = '{0, 7, 1'b1};
      pix_tab[3] = '{1, 7, 1'b1};
      pix_tab[4] = '{1, 3, 1'b1};
      pix_tab[5] = '{2, 0, 1'b0};
      pix_tab[6] = '{-1, 0, 1'b0};
      pix_tab[7] = '{0, -1, 1'b0};
      pix_tab[8] = '{0, 8, 1'b0};
      pix_tab[9] = '{-1, 8, 1'b0};

      Reset           = 1'b0;
      frame_clk       = 1'b0;
      play            = 1'b0;
      done            = 1'b0;
      alive_mask      = 6'd0;
      y_offset        = 10'd40;
      user_ship_x_pos = 10'd600;
      user_ship_y_pos = 10'd440;
      DrawX           = 10'd0;
      DrawY           = 10'd0;
      model_reset();

      repeat (3) @(negedge Clk);
      checkOutput("rst_laser_active", laser_active, 1'b0);
      checkOutput("rst_user_hit", user_hit, 1'b0);
      checkOutput("rst_is_enemy_laser", is_enemy_laser, 1'b0);
      checkOutput("rst_laser_data", enemy_laser_data, 24'hFF0000);
      Reset = 1'b1;

      $display("[TB] first shot after full cooldown");
      repeat (FIRE_PERIOD - 1) applyStimulus(1'b1, 6'b111111);
      checkOutput("no_shot_before_period", laser_active, 1'b0);
      applyStimulus(1'b1, 6'b111111);
      checkOutput("shot_at_period", laser_active, 1'b1);
      for (int i = 0; i < 10; i++) begin
         DrawX = 10'(65 + pix_tab[i].dx);
         DrawY = 10'(72 + pix_tab[i].dy);
         #1;
         checkOutput($sformatf("pix_tab_%0d", i), is_enemy_laser, pix_tab[i].exp_pix);
      end

      $display("[TB] round robin over mask 100100, laser to ground");
      do_done();
      wait_laser(1'b1, 6'b100100, 200, "rr_shot1_launch");
      probe_laser(165, 72, ok);
      checkOutput("rr_shot1_x165", ok, 1'b1);
      h0 = hit_pulses;
      wait_laser(1'b0, 6'b100100, 200, "laser_reaches_ground");
      checkOutput("ground_no_hit", hit_pulses, h0);
      wait_laser(1'b1, 6'b100100, 200, "rr_shot2_launch");
      probe_laser(315, 72, ok);
      checkOutput("rr_shot2_x315", ok, 1'b1);

      $display("[TB] shot from idx 0 strikes user ship");
      do_done();
      user_ship_x_pos = 10'd64;
      user_ship_y_pos = 10'd140;
      wait_laser(1'b1, 6'b111111, 200, "hit_shot_launch");
      probe_laser(65, 72, ok);
      checkOutput("hit_shot_x65", ok, 1'b1);
      h0 = hit_pulses;
      n  = 0;
      while (hit_pulses == h0 && n < 25) begin
         applyStimulus(1'b1, 6'b111111);
         n++;
      end
      checkOutput("single_hit_pulse", hit_pulses - h0, 1);
      checkOutput("hit_frame", n, 16);
      checkOutput("hit_then_cooldown", laser_active, 1'b0);
      user_ship_x_pos = 10'd600;
      user_ship_y_pos = 10'd440;

      $display("[TB] freeze with play low, then done mid-flight");
      do_done();
      wait_laser(1'b1, 6'b111111, 200, "freeze_shot_launch");
      repeat (5) applyStimulus(1'b1, 6'b111111);
      probe_laser(65, 92, ok);
      checkOutput("moved_to_92", ok, 1'b1);
      repeat (10) applyStimulus(1'b0, 6'b111111);
      probe_laser(65, 92, ok);
      checkOutput("frozen_at_92", ok, 1'b1);
      checkOutput("frozen_active", laser_active, 1'b1);
      do_done();

      $display("[TB] empty row at cooldown expiry");
      repeat (FIRE_PERIOD + 5) applyStimulus(1'b1, 6'b000000);
      checkOutput("empty_row_no_shot", laser_active, 1'b0);
      applyStimulus(1'b1, 6'b000001);
      checkOutput("late_mask_fires", laser_active, 1'b1);
      probe_laser(65, 72, ok);
      checkOutput("late_mask_x65", ok, 1'b1);

      $display("[TB] random frames against model");
      for (int ep = 0; ep < 5; ep++) begin
         do_done();
         y_offset        = 10'($urandom_range(0, 100));
         user_ship_y_pos = 10'($urandom_range(int'(y_offset) + 40, 440));
         user_ship_x_pos = 10'(50 * $urandom_range(1, 6) + $urandom_range(0, 40) - 30);
         mask            = 6'($urandom);
         for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 9) == 0) mask = 6'($urandom);
            applyStimulus($urandom_range(0, 9) != 0, mask);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/enemy_fire_ctrl.md
ENEMY_FIRE_CTRL -- requirements
Module: enemy_fire_ctrl

Interface
REQ-001 SHALL have parameter FIRE_PERIOD, default 90, meaning frames of cooldown between enemy shots.
REQ-002 SHALL have parameter LASER_STEP, default 4, meaning pixels the laser descends per frame.
REQ-003 SHALL have parameter ESHIP_W, default 32, meaning enemy/user ship width and height in pixels.
REQ-004 Clk  in  1  50 MHz system clock.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 frame_clk  in  1  ~60 Hz frame strobe; rising edge is detected in the Clk domain.
REQ-007 play  in  1  high while in play state; low freezes all motion and counters.
REQ-008 done  in  1  game finished; clears laser and restarts cooldown.
REQ-009 alive_mask  in  6  bit i high when row ship i+1 (x = 50*(i+1)) is alive.
REQ-010 y_offset  in  10  row top y coordinate.
REQ-011 user_ship_x_pos, user_ship_y_pos  in  10 each  user ship top-left corner.
REQ-012 DrawX, DrawY  in  10 each  current drawing coordinates.
REQ-013 is_enemy_laser  out  1  current pixel lies on the enemy laser.
REQ-014 enemy_laser_data  out  24  RGB of laser pixel, constant 24'hFF0000.
REQ-015 user_hit  out  1  one-Clk pulse when the enemy laser strikes the user ship.
REQ-016 laser_active  out  1  high while a laser is in flight.

Function
REQ-017 SHALL detect frame_clk rising edge via a one-flop delayed copy; all motion/counting happens only on a detected edge ("frame tick").
REQ-018 SHALL implement states IDLE, COOLDOWN, FLYING, HIT.
REQ-019 IDLE -> COOLDOWN on first frame tick with play high; cooldown counter loads FIRE_PERIOD-1.
REQ-020 COOLDOWN: decrement counter per frame tick; at 0 with alive_mask != 0 -> FLYING; at 0 with alive_mask == 0 -> stay COOLDOWN at 0.
REQ-021 Shooter selection: round-robin pointer (0..5); next shooter is the first alive index strictly after the last shooter, wrapping 5->0; pointer resets to 5 so first shot picks lowest alive index.
REQ-022 On entering FLYING: laser_x = 50*(idx+1) + ESHIP_W/2 - 1, laser_y = y_offset + ESHIP_W; laser is 2 px wide, 8 px tall.
REQ-023 FLYING: each frame tick laser_y += LASER_STEP; if resulting laser_y >= 472 -> COOLDOWN (reload counter), no hit.
REQ-024 Hit test evaluated every Clk in FLYING: laser box overlaps user box [x, x+ESHIP_W) x [y, y+ESHIP_W) -> HIT.
REQ-025 HIT: assert user_hit for exactly that one Clk, then -> COOLDOWN with counter reloaded.
REQ-026 Hit and off-screen on the same tick: hit wins.
REQ-027 is_enemy_laser = laser_active and DrawX in [laser_x, laser_x+1] and DrawY in [laser_y, laser_y+7]; combinational.
REQ-028 laser_active high only in FLYING.
REQ-029 play low: state, counter, laser position hold; hit test suspended; is_enemy_laser still drawn.
REQ-030 done high (any state): -> IDLE next Clk, laser cleared, pointer to 5, user_hit low; done has priority over all events.
REQ-031 Shooter dying mid-flight does not cancel its laser.
REQ-032 All arithmetic 10-bit unsigned; laser_y never wraps (exit check precedes wrap).

Reset
REQ-033 On Reset low: state IDLE, counter 0, pointer 5, laser_x/laser_y 0, frame edge flop 0; outputs is_enemy_laser 0, user_hit 0, laser_active 0, enemy_laser_data 24'hFF0000.

Structure
REQ-034 State enum, ship x table (50..300), laser size constants and colour SHALL live in shared package galaga_pkg.
REQ-035 Round-robin shooter picker SHALL be sub-module rr_shooter_sel (alive_mask, last_idx -> next_idx, valid).

Verification
REQ-036 Reset release, play=1, alive_mask=6'b111111, 90 frame ticks -> FLYING, laser_x=65, laser_y=y_offset+32.
REQ-037 alive_mask=6'b100100, two shots -> shooters idx 2 (x=165) then idx 5 (x=315).
REQ-038 user ship at (64, y_offset+100), shot from idx 0 -> user_hit single-Clk pulse within 25 frame ticks, then COOLDOWN.
REQ-039 user ship away from path -> laser reaches y>=472, laser_active falls, no user_hit.
REQ-040 play low mid-flight for 10 ticks -> laser_y unchanged; done asserted mid-flight -> IDLE, laser_active 0 next Clk.
REQ-041 alive_mask=0 at cooldown expiry -> no shot; set mask 6'b000001 -> FLYING on next frame tick.
